// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter slice.
//   src_e        : requester id carried through the in-order response FIFO
//   SIZE_B/H/W   : m_size / *_size transfer size encodings
//   arb_state_e  : grant-hold state of the arbiter
package sram_port_arbiter_pkg;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_HOLD_I = 2'd1,
        ARB_HOLD_D = 2'd2
    } arb_state_e;

    function automatic src_e other_src(input src_e s);
        return (s == SRC_INST) ? SRC_DATA : SRC_INST;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_arb_id_fifo.sv
// arb_id_fifo: 1-bit wide (src_e), DEPTH deep synchronous FIFO recording which
// port issued each accepted master request, in acceptance order.
// Ports:
//   clk, reset   clock, synchronous active-high reset (clears pointers/count)
//   push_i       enqueue push_id_i (ignored when full)
//   push_id_i    source id to enqueue
//   pop_i        dequeue head (ignored when empty)
//   head_o       oldest stored id
//   count_o      occupancy, 0..DEPTH
//   full_o       count_o == DEPTH
//   empty_o      count_o == 0
module arb_id_fifo
    import sram_port_arbiter_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  src_e             push_id_i,
    input  logic             pop_i,
    output src_e             head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    src_e             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: validity is carried by count/pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_id_i;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM-like master port between the instruction
// (i_*) and data (d_*) requesters with zero added latency. Accepted requests
// are tracked in arb_id_fifo so each m_data_ok returns to its issuing port.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   i_/d_ req,wr,size,addr,wstrb,wdata  requester inputs
//   i_/d_ addr_ok,data_ok,rdata         requester responses
//   m_ req,wr,size,addr,wstrb,wdata     shared master request
//   m_addr_ok, m_data_ok, m_rdata       master responses (in request order)
// Configuration: define ARB_ROUND_ROBIN_EN to alternate grants on ties;
// otherwise data has fixed priority over instruction.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned OTD_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic                i_wr,
    input  logic [1:0]          i_size,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W/8-1:0] i_wstrb,
    input  logic [DATA_W-1:0]   i_wdata,
    output logic                i_addr_ok,
    output logic                i_data_ok,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_wr,
    input  logic [1:0]          d_size,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W/8-1:0] d_wstrb,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_addr_ok,
    output logic                d_data_ok,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_req,
    output logic                m_wr,
    output logic [1:0]          m_size,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_addr_ok,
    input  logic                m_data_ok,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int unsigned CNT_W = $clog2(OTD_DEPTH) + 1;

    arb_state_e       state_q, state_d;
    logic             grant_vld;
    src_e             grant_src;
    logic             sel_d;
    logic             hs;
    logic             pop;
    src_e             head_src;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

`ifdef ARB_ROUND_ROBIN_EN
    src_e last_q;
`endif

    // Hold states lock the grant until the master accepts, so a stalled
    // request is never swapped for the other port's request mid-flight.
    always_comb begin
        grant_vld = 1'b0;
        grant_src = SRC_INST;
        if (!fifo_full) begin
            case (state_q)
                ARB_HOLD_D: begin
                    grant_vld = 1'b1;
                    grant_src = SRC_DATA;
                end
                ARB_HOLD_I: begin
                    grant_vld = 1'b1;
                    grant_src = SRC_INST;
                end
                default: begin
                    if (d_req && i_req) begin
                        grant_vld = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        grant_src = other_src(last_q);
`else
                        grant_src = SRC_DATA;
`endif
                    end else if (d_req) begin
                        grant_vld = 1'b1;
                        grant_src = SRC_DATA;
                    end else if (i_req) begin
                        grant_vld = 1'b1;
                        grant_src = SRC_INST;
                    end
                end
            endcase
        end
    end

    always_comb begin
        state_d = ARB_IDLE;
        if (m_req && !m_addr_ok) begin
            state_d = sel_d ? ARB_HOLD_D : ARB_HOLD_I;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Resets to instruction so the first tie after reset goes to data.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= SRC_INST;
        end else if (hs) begin
            last_q <= grant_src;
        end
    end
`endif

    assign sel_d   = (grant_src == SRC_DATA);
    assign m_req   = !reset && grant_vld && (sel_d ? d_req : i_req);
    assign m_wr    = sel_d ? d_wr    : i_wr;
    assign m_size  = sel_d ? d_size  : i_size;
    assign m_addr  = sel_d ? d_addr  : i_addr;
    assign m_wstrb = sel_d ? d_wstrb : i_wstrb;
    assign m_wdata = sel_d ? d_wdata : i_wdata;

    assign hs        = m_req && m_addr_ok;
    assign i_addr_ok = hs && !sel_d;
    assign d_addr_ok = hs && sel_d;

    // A response with nothing outstanding is dropped rather than routed.
    assign pop       = !reset && m_data_ok && !fifo_empty;
    assign i_data_ok = pop && (head_src == SRC_INST);
    assign d_data_ok = pop && (head_src == SRC_DATA);
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

    arb_id_fifo #(
        .DEPTH(OTD_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_i   (hs),
        .push_id_i(grant_src),
        .pop_i    (pop),
        .head_o   (head_src),
        .count_o  (fifo_count),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

`ifndef SYNTHESIS
    a_no_stray_data_ok: assert property (@(posedge clk) disable iff (reset)
        !(m_data_ok && fifo_empty));
`endif

endmodule
